// File: rtl/seq_detect_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

  localparam int unsigned MAX_LEN_LIMIT = 32;

  localparam logic [MAX_LEN_LIMIT-1:0] DEF_PATTERN = 32'h0000_0006;
  localparam int unsigned              DEF_LEN     = 4;
  localparam logic                     DEF_OVERLAP = 1'b1;

  typedef enum logic {
    MODE_RESTART = 1'b0,
    MODE_OVERLAP = 1'b1
  } overlap_mode_e;

  // Low len bits set; callers truncate to their own pattern width.
  function automatic logic [MAX_LEN_LIMIT-1:0] len_mask(input int unsigned len);
    logic [MAX_LEN_LIMIT-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LEN_LIMIT; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic cfg_len_ok(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module seq_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector: history shift register,
// fill tracking, masked compare, registered match pulse and match counter.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int unsigned          MAX_LEN     = 8,
  parameter int unsigned          CNT_W       = 16,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(seq_detect_pkg::DEF_PATTERN),
  parameter int unsigned          DEF_LEN     = seq_detect_pkg::DEF_LEN,
  parameter logic                 DEF_OVERLAP = seq_detect_pkg::DEF_OVERLAP,
  localparam int unsigned         LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               in,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  overlap_mode_e      overlap_q;
  logic               match_q, cfg_err_q;

  logic [MAX_LEN-1:0] mask_cur, mask_cfg;
  logic               accept, cfg_ok, hit;

  always_comb begin
    mask_cur = MAX_LEN'(len_mask(32'(len_q)));
    mask_cfg = MAX_LEN'(len_mask(32'(cfg_len)));
    cfg_ok   = cfg_len_ok(32'(cfg_len), MAX_LEN);
    accept   = in_valid && !clr && !cfg_we;
    hist_d   = {hist_q[MAX_LEN-2:0], in};
    fill_d   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    hit      = accept && (fill_d >= len_q) && (((hist_d ^ pat_q) & mask_cur) == '0);
  end

  // clr outranks cfg_we, which outranks an accepted bit; a bit arriving
  // alongside either is dropped (accept is already low in that case).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= DEF_PATTERN & MAX_LEN'(len_mask(DEF_LEN));
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= overlap_mode_e'(DEF_OVERLAP);
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      match_q   <= hit;
      cfg_err_q <= cfg_we && !cfg_ok;
      if (clr || (cfg_we && cfg_ok)) begin
        hist_q <= '0;
        fill_q <= '0;
      end else if (accept) begin
        hist_q <= hist_d;
        fill_q <= (hit && (overlap_q == MODE_RESTART)) ? '0 : fill_d;
      end
      if (cfg_we && cfg_ok) begin
        pat_q     <= cfg_pattern & mask_cfg;
        len_q     <= cfg_len;
        overlap_q <= overlap_mode_e'(cfg_overlap);
      end
    end
  end

  seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (hit),
    .clr_i (clr),
    .cnt_o (match_cnt)
  );

  assign match   = match_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: vector table plus hand-written corner sequences.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, cfg_we = 1'b0, cfg_overlap = 1'b0;
  logic       in_valid = 1'b0, in_b = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_err, match;
  logic [3:0] match_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_detect_prog #(
    .MAX_LEN (8),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in          (in_b),
    .match       (match),
    .match_cnt   (match_cnt)
  );

  typedef struct {
    string      name;
    logic       v, b, c, w;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       em, ee;
    logic [3:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic v, logic b, logic c, logic w,
                              logic [7:0] pat, logic [3:0] len, logic ovl,
                              logic em, logic ee, logic [3:0] ec);
    vec_t r;
    r.name = nm; r.v = v; r.b = b; r.c = c; r.w = w;
    r.pat = pat; r.len = len; r.ovl = ovl;
    r.em = em; r.ee = ee; r.ec = ec;
    return r;
  endfunction

  function automatic vec_t d(string nm, logic b, logic em, logic [3:0] ec);
    return mk(nm, 1'b1, b, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, em, 1'b0, ec);
  endfunction

  task automatic check1(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic em, input logic ee, input logic [3:0] ec);
    check1({nm, ".match"}, {3'b000, match}, {3'b000, em});
    check1({nm, ".cfg_err"}, {3'b000, cfg_err}, {3'b000, ee});
    check1({nm, ".cnt"}, match_cnt, ec);
  endtask

  task automatic tick(input logic v, input logic b, input logic c, input logic w);
    in_valid = v; in_b = b; clr = c; cfg_we = w;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
  endtask

  logic [7:0] a5;
  logic [3:0] exp_c;

  initial begin
    // defaults: overlapping 0110
    vecs.push_back(d("p1b1", 0, 0, 0));
    vecs.push_back(d("p1b2", 1, 0, 0));
    vecs.push_back(d("p1b3", 1, 0, 0));
    vecs.push_back(d("p1b4", 0, 1, 1));
    vecs.push_back(d("p1b5", 1, 0, 1));
    vecs.push_back(d("p1b6", 1, 0, 1));
    vecs.push_back(d("p1b7", 0, 1, 2));
    // 0110 restart mode: second match needs four fresh bits
    vecs.push_back(mk("p2cfg", 0, 0, 0, 1, 8'h06, 4'd4, 1'b0, 0, 0, 2));
    vecs.push_back(d("p2b1", 0, 0, 2));
    vecs.push_back(d("p2b2", 1, 0, 2));
    vecs.push_back(d("p2b3", 1, 0, 2));
    vecs.push_back(d("p2b4", 0, 1, 3));
    vecs.push_back(d("p2b5", 1, 0, 3));
    vecs.push_back(d("p2b6", 1, 0, 3));
    vecs.push_back(d("p2b7", 0, 0, 3));
    vecs.push_back(d("p2b8", 1, 0, 3));
    vecs.push_back(d("p2b9", 1, 0, 3));
    vecs.push_back(d("p2b10", 0, 1, 4));
    // illegal lengths rejected; history and config survive
    vecs.push_back(mk("p4cfg", 0, 0, 0, 1, 8'h06, 4'd4, 1'b1, 0, 0, 4));
    vecs.push_back(d("p4b1", 0, 0, 4));
    vecs.push_back(d("p4b2", 1, 0, 4));
    vecs.push_back(mk("p4len0", 1, 0, 0, 1, 8'hFF, 4'd0, 1'b0, 0, 1, 4));
    vecs.push_back(mk("p4idle0", 0, 0, 0, 0, 8'h00, 4'd0, 1'b0, 0, 0, 4));
    vecs.push_back(mk("p4len9", 1, 0, 0, 1, 8'hFF, 4'd9, 1'b0, 0, 1, 4));
    vecs.push_back(mk("p4idle1", 0, 0, 0, 0, 8'h00, 4'd0, 1'b0, 0, 0, 4));
    vecs.push_back(d("p4b3", 1, 0, 4));
    vecs.push_back(d("p4b4", 0, 1, 5));

    #12;
    chk("reset", 0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      set_cfg(vecs[i].pat, vecs[i].len, vecs[i].ovl);
      tick(vecs[i].v, vecs[i].b, vecs[i].c, vecs[i].w);
      chk(vecs[i].name, vecs[i].em, vecs[i].ee, vecs[i].ec);
    end

    // 8-bit A5 with idle gaps between bits
    set_cfg(8'hA5, 4'd8, 1'b1);
    tick(0, 0, 0, 1);
    chk("p3cfg", 0, 0, 5);
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (i % 4); g++) begin
        tick(0, ~a5[7-i], 0, 0);
        chk($sformatf("p3gap%0d_%0d", i, g), 0, 0, 5);
      end
      tick(1, a5[7-i], 0, 0);
      chk($sformatf("p3b%0d", i), (i == 7), 0, (i == 7) ? 4'd6 : 4'd5);
    end

    // len=1 pattern 1: saturate the 4-bit counter, then clear
    set_cfg(8'h01, 4'd1, 1'b0);
    tick(0, 0, 0, 1);
    chk("p5cfg", 0, 0, 6);
    for (int k = 1; k <= 20; k++) begin
      exp_c = (6 + k > 15) ? 4'd15 : 4'(6 + k);
      tick(1, 1, 0, 0);
      chk($sformatf("p5sat%0d", k), 1, 0, exp_c);
    end
    tick(1, 1, 1, 0);
    chk("p5clr", 0, 0, 0);
    tick(1, 1, 0, 0);
    chk("p5one", 1, 0, 1);
    tick(1, 0, 0, 0);
    chk("p5zero", 0, 0, 1);

    // cfg_we on the final bit discards it and restarts fill
    set_cfg(8'h06, 4'd4, 1'b1);
    tick(0, 0, 0, 1);
    chk("p6cfg", 0, 0, 1);
    tick(1, 0, 0, 0); chk("p6a1", 0, 0, 1);
    tick(1, 1, 0, 0); chk("p6a2", 0, 0, 1);
    tick(1, 1, 0, 0); chk("p6a3", 0, 0, 1);
    tick(1, 0, 0, 1); chk("p6weLast", 0, 0, 1);
    tick(1, 1, 0, 0); chk("p6f1", 0, 0, 1);
    tick(1, 1, 0, 0); chk("p6f2", 0, 0, 1);
    tick(1, 0, 0, 0); chk("p6f3", 0, 0, 1);
    tick(1, 0, 0, 0); chk("p6s1", 0, 0, 1);
    tick(1, 1, 0, 0); chk("p6s2", 0, 0, 1);
    tick(1, 1, 0, 0); chk("p6s3", 0, 0, 1);
    tick(1, 0, 0, 0); chk("p6s4", 1, 0, 2);

    // async reset after three of four pattern bits
    tick(1, 0, 0, 0); chk("p7a1", 0, 0, 2);
    tick(1, 1, 0, 0); chk("p7a2", 0, 0, 2);
    tick(1, 1, 0, 0); chk("p7a3", 0, 0, 2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("p7rst", 0, 0, 0);
    rst_n = 1'b1;
    tick(1, 0, 0, 0); chk("p7last", 0, 0, 0);
    tick(1, 1, 0, 0); chk("p7r2", 0, 0, 0);
    tick(1, 1, 0, 0); chk("p7r3", 0, 0, 0);
    tick(1, 0, 0, 0); chk("p7r4", 1, 0, 1);
    tick(0, 0, 0, 0); chk("p7idle", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
